// File: rtl/bicubic_pkg.sv
// Shared types and constants for the bicubic upscale schedulers.
// Holds the vertical weight-code table, phase type and scheduler states.
package bicubic_pkg;

    localparam int PHASES = 4;
    localparam int TAPS = 4;
    localparam int WCODE_W = 3;

    typedef logic [1:0] phase_t;
    typedef logic [WCODE_W-1:0] wcode_t;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } sched_state_t;

    // WCODE[phase][tap]; the table is mirror-symmetric across phases.
    localparam wcode_t WCODE [PHASES][TAPS] = '{
        '{3'd0, 3'd1, 3'd2, 3'd3},
        '{3'd4, 3'd5, 3'd6, 3'd7},
        '{3'd7, 3'd6, 3'd5, 3'd4},
        '{3'd3, 3'd2, 3'd1, 3'd0}
    };

endpackage

// File: rtl/bicubic_valid_tracker.sv
// Valid/tag shift register of configurable depth with a shared enable.
// Ports: clk, rst, ena, in_valid/in_tag (head), out_valid/out_tag (tail).
module bicubic_valid_tracker #(
    parameter int DEPTH = 1,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst ^ ena;
            assign out_valid = in_valid;
            assign out_tag = in_tag;
        end else begin : g_shift
            logic [DEPTH-1:0] vld;
            logic [TAG_W-1:0] tag [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        tag[i] <= '0;
                    end
                end else if (ena) begin
                    vld[0] <= in_valid;
                    tag[0] <= in_tag;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld[i] <= vld[i-1];
                        tag[i] <= tag[i-1];
                    end
                end
            end

            assign out_valid = vld[DEPTH-1];
            assign out_tag = tag[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/bicubic_stage2_scheduler.sv
// Stage-2 (vertical) bicubic scheduler: one 4-tap column in, four phases out.
// Ports: in_* column stream, mult_* datapath drive/return, out_* result stream.
module bicubic_stage2_scheduler
    import bicubic_pkg::*;
#(
    parameter int INTER_PRODUCT_WIDTH = 24,
    parameter int PRODUCT_WIDTH = 32,
    parameter int MULT_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [4*INTER_PRODUCT_WIDTH-1:0] in_pix,
    output logic                             mult_ena,
    output logic [2:0]                       mult_weight_1,
    output logic [2:0]                       mult_weight_2,
    output logic [2:0]                       mult_weight_3,
    output logic [2:0]                       mult_weight_4,
    output logic [INTER_PRODUCT_WIDTH-1:0]   mult_pixel_1,
    output logic [INTER_PRODUCT_WIDTH-1:0]   mult_pixel_2,
    output logic [INTER_PRODUCT_WIDTH-1:0]   mult_pixel_3,
    output logic [INTER_PRODUCT_WIDTH-1:0]   mult_pixel_4,
    input  logic [PRODUCT_WIDTH-1:0]         mult_product,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PRODUCT_WIDTH-1:0]         out_data,
    output logic [1:0]                       out_phase,
    output logic                             out_last
);

    localparam int IW = INTER_PRODUCT_WIDTH;

    sched_state_t state, state_d;
    phase_t ph, ph_d;
    logic [4*IW-1:0] hold_pix;
    logic held;
    logic adv;
    logic issue;
    logic load;

    // Last issued datapath inputs, replayed while not issuing.
    wcode_t wreg [TAPS];
    logic [IW-1:0] preg [TAPS];
    wcode_t wdrv [TAPS];
    logic [IW-1:0] pdrv [TAPS];

    logic tail_valid;
    phase_t tail_phase;

    assign held = (state == S_BUSY);
    assign adv = !out_valid || out_ready;
    assign mult_ena = adv;
    assign issue = held && adv;
    assign in_ready = !held || (adv && ph == 2'd3);
    assign load = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ph <= '0;
        end else begin
            state <= state_d;
            ph <= ph_d;
        end
    end

    // A load in the phase-3 issue cycle keeps the scheduler busy.
    always_comb begin
        state_d = state;
        ph_d = ph;
        if (issue) begin
            ph_d = ph + 2'd1;
            if (ph == 2'd3) begin
                state_d = S_IDLE;
            end
        end
        if (load) begin
            state_d = S_BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pix <= '0;
        end else if (load) begin
            hold_pix <= in_pix;
        end
    end

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            wdrv[k] = wreg[k];
            pdrv[k] = preg[k];
            if (issue) begin
                wdrv[k] = WCODE[ph][k];
                pdrv[k] = hold_pix[k*IW +: IW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                wreg[k] <= '0;
                preg[k] <= '0;
            end
        end else if (issue) begin
            for (int k = 0; k < TAPS; k++) begin
                wreg[k] <= wdrv[k];
                preg[k] <= pdrv[k];
            end
        end
    end

    assign mult_weight_1 = wdrv[0];
    assign mult_weight_2 = wdrv[1];
    assign mult_weight_3 = wdrv[2];
    assign mult_weight_4 = wdrv[3];
    assign mult_pixel_1 = pdrv[0];
    assign mult_pixel_2 = pdrv[1];
    assign mult_pixel_3 = pdrv[2];
    assign mult_pixel_4 = pdrv[3];

    bicubic_valid_tracker #(
        .DEPTH(MULT_LATENCY),
        .TAG_W(2)
    ) u_tracker (
        .clk(clk),
        .rst(rst),
        .ena(adv),
        .in_valid(issue),
        .in_tag(ph),
        .out_valid(tail_valid),
        .out_tag(tail_phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_phase <= '0;
        end else if (adv) begin
            if (tail_valid) begin
                out_valid <= 1'b1;
                out_data <= mult_product;
                out_phase <= tail_phase;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_last = (out_phase == 2'd3);

endmodule

// File: tb/tb_bicubic_stage2_scheduler.sv
// Bench for bicubic_stage2_scheduler: latency 0, 1 and 2 builds side by side.
// Each build drives its own behavioural datapath; a scoreboard tracks results.
module tb_bicubic_stage2_scheduler;

    localparam int IW = 24;
    localparam int PW = 32;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic [4*IW-1:0] in_pix;

    logic ir [N];
    logic ov [N];
    logic ol [N];
    logic ena [N];
    logic [PW-1:0] od [N];
    logic [1:0] oph [N];
    logic [11:0] wts [N];
    logic [4*IW-1:0] pix [N];

    int checks = 0;
    int passes = 0;
    int acc_cnt [N];
    int out_cnt [N];

    typedef struct {
        logic [PW-1:0] d;
        logic [1:0] p;
    } exp_t;

    exp_t sb [N][$];

    always #5 clk = ~clk;

    // Weight codes per phase, packed {tap3, tap2, tap1, tap0}.
    function automatic logic [11:0] exp_w(int p);
        case (p)
            0: return {3'd3, 3'd2, 3'd1, 3'd0};
            1: return {3'd7, 3'd6, 3'd5, 3'd4};
            2: return {3'd4, 3'd5, 3'd6, 3'd7};
            default: return {3'd0, 3'd1, 3'd2, 3'd3};
        endcase
    endfunction

    // Stand-in datapath: sum of pixel times (code + 1).
    function automatic logic [PW-1:0] dp(logic [11:0] w, logic [4*IW-1:0] p);
        logic [PW-1:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            s = s + 32'(p[k*IW +: IW]) * (32'(w[k*3 +: 3]) + 32'd1);
        end
        return s;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [2:0] w1, w2, w3, w4;
        logic [IW-1:0] p1, p2, p3, p4;
        logic me;
        logic [PW-1:0] prod, comb_p, st1, st2;

        bicubic_stage2_scheduler #(
            .INTER_PRODUCT_WIDTH(IW),
            .PRODUCT_WIDTH(PW),
            .MULT_LATENCY(g)
        ) dut (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid),
            .in_ready(ir[g]),
            .in_pix(in_pix),
            .mult_ena(me),
            .mult_weight_1(w1),
            .mult_weight_2(w2),
            .mult_weight_3(w3),
            .mult_weight_4(w4),
            .mult_pixel_1(p1),
            .mult_pixel_2(p2),
            .mult_pixel_3(p3),
            .mult_pixel_4(p4),
            .mult_product(prod),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_data(od[g]),
            .out_phase(oph[g]),
            .out_last(ol[g])
        );

        assign comb_p = dp({w4, w3, w2, w1}, {p4, p3, p2, p1});

        always @(posedge clk) begin
            if (me) begin
                st1 <= comb_p;
                st2 <= st1;
            end
        end

        assign prod = (g == 0) ? comb_p : ((g == 1) ? st1 : st2);
        assign ena[g] = me;
        assign wts[g] = {w4, w3, w2, w1};
        assign pix[g] = {p4, p3, p2, p1};
    end

    // Scoreboard: each accepted word yields four results in phase order.
    always @(negedge clk) begin
        exp_t e;
        #2;
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                sb[g].delete();
            end else begin
                if (ov[g] && out_ready) begin
                    checks++;
                    out_cnt[g]++;
                    if (sb[g].size() == 0) begin
                        $display("FAIL sb_extra[L%0d]: got phase %0d data %0h, expected none",
                                 g, oph[g], od[g]);
                    end else begin
                        e = sb[g].pop_front();
                        if (od[g] !== e.d || oph[g] !== e.p || ol[g] !== (e.p == 2'd3))
                            $display("FAIL sb_data[L%0d]: got %0h/ph%0d/last%0b, expected %0h/ph%0d",
                                     g, od[g], oph[g], ol[g], e.d, e.p);
                        else
                            passes++;
                    end
                end
                if (in_valid && ir[g]) begin
                    acc_cnt[g]++;
                    for (int p = 0; p < 4; p++) begin
                        e.d = dp(exp_w(p), in_pix);
                        e.p = 2'(p);
                        sb[g].push_back(e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_pix = '0;
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            checks++;
            if ({ir[g], ov[g], ol[g], ena[g]} !== 4'b1001)
                $display("FAIL reset_ctrl[L%0d]: got %b, expected 1001", g,
                         {ir[g], ov[g], ol[g], ena[g]});
            else
                passes++;
            checks++;
            if (od[g] !== '0 || oph[g] !== 2'd0)
                $display("FAIL reset_out[L%0d]: got %0h/%0d, expected 0/0", g, od[g], oph[g]);
            else
                passes++;
            checks++;
            if (wts[g] !== '0 || pix[g] !== '0)
                $display("FAIL reset_mult[L%0d]: got %0h/%0h, expected 0/0", g, wts[g], pix[g]);
            else
                passes++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [4*IW-1:0] word;
        int ph;
        word = {24'd400, 24'd300, 24'd200, 24'd100};
        @(negedge clk);
        in_valid = 1'b1;
        in_pix = word;
        out_ready = 1'b1;
        #1;
        for (int g = 0; g < N; g++) begin
            checks++;
            if (ir[g] !== 1'b1) $display("FAIL single_ready0[L%0d]: got %b, expected 1", g, ir[g]);
            else passes++;
        end
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            for (int g = 0; g < N; g++) begin
                checks++;
                if (ov[g] !== (n >= 2 + g && n <= 5 + g))
                    $display("FAIL single_valid[L%0d] n=%0d: got %b", g, n, ov[g]);
                else
                    passes++;
                if (n >= 2 + g && n <= 5 + g) begin
                    ph = n - 2 - g;
                    checks++;
                    if (oph[g] !== 2'(ph) || ol[g] !== (ph == 3) || od[g] !== dp(exp_w(ph), word))
                        $display("FAIL single_out[L%0d] n=%0d: got %0h/ph%0d/last%0b, expected %0h/ph%0d",
                                 g, n, od[g], oph[g], ol[g], dp(exp_w(ph), word), ph);
                    else
                        passes++;
                end
                if (n <= 4) begin
                    checks++;
                    if (wts[g] !== exp_w(n - 1) || pix[g] !== word || ir[g] !== (n == 4) || ena[g] !== 1'b1)
                        $display("FAIL single_issue[L%0d] n=%0d: got w=%0h rdy=%b, expected w=%0h rdy=%b",
                                 g, n, wts[g], ir[g], exp_w(n - 1), (n == 4));
                    else
                        passes++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4*IW-1:0] w [3];
        int j;
        j = 0;
        for (int i = 0; i < 3; i++) w[i] = {$urandom(), $urandom(), $urandom()};
        out_ready = 1'b1;
        for (int n = 0; n <= 18; n++) begin
            @(negedge clk);
            in_valid = (j < 3);
            in_pix = w[(j < 3) ? j : 0];
            #1;
            if (n >= 1 && n <= 16) begin
                for (int g = 0; g < N; g++) begin
                    checks++;
                    if (ov[g] !== (n >= 2 + g && n <= 13 + g))
                        $display("FAIL b2b_valid[L%0d] n=%0d: got %b", g, n, ov[g]);
                    else
                        passes++;
                    if (n <= 12) begin
                        checks++;
                        if (ir[g] !== (n % 4 == 0))
                            $display("FAIL b2b_ready[L%0d] n=%0d: got %b, expected %b",
                                     g, n, ir[g], (n % 4 == 0));
                        else
                            passes++;
                    end
                end
            end
            if (in_valid && ir[0]) j++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [4*IW-1:0] w [2];
        logic [PW-1:0] pd [N];
        logic [1:0] pp [N];
        logic pv [N];
        int j, stall, rel;
        bit done;
        j = 0;
        stall = 0;
        rel = -1;
        done = 1'b0;
        w[0] = {$urandom(), $urandom(), $urandom()};
        w[1] = {$urandom(), $urandom(), $urandom()};
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!done && ov[1] && oph[1] == 2'd1) begin
                done = 1'b1;
                stall = 5;
            end
            out_ready = (stall == 0);
            in_valid = (j < 2);
            in_pix = w[(j < 2) ? j : 0];
            #1;
            if (stall > 0) begin
                for (int g = 0; g < N; g++) begin
                    checks++;
                    if (ena[g] !== !ov[g])
                        $display("FAIL stall_ena[L%0d]: got %b, valid %b", g, ena[g], ov[g]);
                    else
                        passes++;
                    if (stall < 5 && pv[g]) begin
                        checks++;
                        if (!ov[g] || od[g] !== pd[g] || oph[g] !== pp[g])
                            $display("FAIL stall_hold[L%0d]: got %0h/ph%0d, expected %0h/ph%0d",
                                     g, od[g], oph[g], pd[g], pp[g]);
                        else
                            passes++;
                    end
                    pd[g] = od[g];
                    pp[g] = oph[g];
                    pv[g] = ov[g];
                end
                checks++;
                if (!ov[1] || oph[1] !== 2'd1)
                    $display("FAIL stall_ph1: got valid %b phase %0d, expected 1/1", ov[1], oph[1]);
                else
                    passes++;
                stall--;
                if (stall == 0) rel = n;
            end
            if (rel >= 0 && n == rel + 2) begin
                checks++;
                if (!ov[1] || oph[1] !== 2'd2)
                    $display("FAIL stall_resume: got valid %b phase %0d, expected 1/2", ov[1], oph[1]);
                else
                    passes++;
            end
            if (in_valid && ir[1]) j++;
        end
        checks++;
        if (!done) $display("FAIL stall_trigger: got no phase-1 output, expected one");
        else passes++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int cntv [N];
        bit seen [N];
        for (int n = 0; n <= 5; n++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (n == 0 || n == 4);
            in_pix = {$urandom(), $urandom(), $urandom()};
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int g = 0; g < N; g++) begin
            checks++;
            if (ov[g] !== 1'b0 || ir[g] !== 1'b1 || od[g] !== '0)
                $display("FAIL midrst[L%0d]: got valid %b ready %b data %0h, expected 0/1/0",
                         g, ov[g], ir[g], od[g]);
            else
                passes++;
            cntv[g] = 0;
            seen[g] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_pix = {$urandom(), $urandom(), $urandom()};
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            for (int g = 0; g < N; g++) begin
                if (ov[g]) begin
                    cntv[g]++;
                    if (!seen[g]) begin
                        seen[g] = 1'b1;
                        checks++;
                        if (oph[g] !== 2'd0)
                            $display("FAIL midrst_first[L%0d]: got phase %0d, expected 0", g, oph[g]);
                        else
                            passes++;
                    end
                end
            end
        end
        for (int g = 0; g < N; g++) begin
            checks++;
            if (cntv[g] !== 4) $display("FAIL midrst_count[L%0d]: got %0d, expected 4", g, cntv[g]);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int g = 0; g < N; g++) begin
            acc_cnt[g] = 0;
            out_cnt[g] = 0;
        end
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_pix = {$urandom(), $urandom(), $urandom()};
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(negedge clk);
        #3;
        for (int g = 0; g < N; g++) begin
            checks++;
            if (sb[g].size() != 0 || out_cnt[g] != 4 * acc_cnt[g] || acc_cnt[g] == 0)
                $display("FAIL random_drain[L%0d]: got %0d outputs for %0d words, %0d pending",
                         g, out_cnt[g], acc_cnt[g], sb[g].size());
            else
                passes++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_pix = '0;
        for (int g = 0; g < N; g++) begin
            acc_cnt[g] = 0;
            out_cnt[g] = 0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
